// File: rtl/conv_arbiter_if.sv
// conv_arbiter_if -- bundle of the request, shared-converter and response
// signals of conv_arbiter.
//   slave  : the arbiter side (takes requests and conv_out, drives the rest)
//   master : the environment side (requesters, converter, responders)
interface conv_arbiter_if #(parameter int W = 4);
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_data,  req1_data;
  logic         req0_mode,  req1_mode;
  logic [W-1:0] conv_in;
  logic         conv_mode;
  logic [W-1:0] conv_out;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready, rsp1_ready;
  logic [W-1:0] rsp_data;
  logic         busy;
  logic [7:0]   done_cnt;

  modport slave (
    input  req0_valid, req1_valid, req0_data, req1_data, req0_mode, req1_mode,
    input  conv_out, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, conv_in, conv_mode,
    output rsp0_valid, rsp1_valid, rsp_data, busy, done_cnt
  );

  modport master (
    output req0_valid, req1_valid, req0_data, req1_data, req0_mode, req1_mode,
    output conv_out, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, conv_in, conv_mode,
    input  rsp0_valid, rsp1_valid, rsp_data, busy, done_cnt
  );
endinterface

// File: rtl/conv_arbiter.sv
// conv_arbiter -- round-robin arbiter sharing one combinational
// binary<->Gray converter between two requesters.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : conv_arbiter_if.slave
//          req{0,1}_{valid,ready,data,mode} : request channels (mode 0 = bin->Gray, 1 = Gray->bin)
//          conv_in/conv_mode -> converter, conv_out <- converter
//          rsp{0,1}_{valid,ready}, rsp_data : response channels (shared data)
//          busy : FSM not IDLE ; done_cnt : completed transactions, wraps
// One transaction takes IDLE (accept) -> CONV (capture conv_out) -> RESP
// (hold until consumed), so peak rate is one per three cycles.
module conv_arbiter #(
  parameter int W = 4
) (
  input  logic          clk,
  input  logic          rst,
  conv_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

  state_t state;
  logic   gnt_id;
  logic   last_id;
  logic   pick;
  logic   any_vld;
  logic   rsp_hs;

  // Round-robin: a lone requester wins; on contention the one not served
  // last wins. last_id resets to 1 so requester 0 wins the first tie.
  always_comb begin
    pick = 1'b0;
    if (bus.req0_valid && bus.req1_valid) pick = ~last_id;
    else if (bus.req1_valid)              pick = 1'b1;
  end

  assign any_vld = bus.req0_valid | bus.req1_valid;

  // Ready is combinational in IDLE; gated by rst so it reads 0 during reset.
  assign bus.req0_ready = !rst && (state == IDLE) && bus.req0_valid && !pick;
  assign bus.req1_ready = !rst && (state == IDLE) && bus.req1_valid &&  pick;

  assign bus.busy = (state != IDLE);

  // Only the granted channel's ready counts; the other is ignored.
  assign rsp_hs = gnt_id ? (bus.rsp1_valid && bus.rsp1_ready)
                         : (bus.rsp0_valid && bus.rsp0_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      gnt_id         <= 1'b0;
      last_id        <= 1'b1;
      bus.conv_in    <= '0;
      bus.conv_mode  <= 1'b0;
      bus.rsp_data   <= '0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.done_cnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: if (any_vld) begin
          bus.conv_in   <= pick ? bus.req1_data : bus.req0_data;
          bus.conv_mode <= pick ? bus.req1_mode : bus.req0_mode;
          gnt_id        <= pick;
          state         <= CONV;
        end
        CONV: begin
          bus.rsp_data   <= bus.conv_out;
          bus.rsp0_valid <= !gnt_id;
          bus.rsp1_valid <=  gnt_id;
          state          <= RESP;
        end
        RESP: if (rsp_hs) begin
          bus.rsp0_valid <= 1'b0;
          bus.rsp1_valid <= 1'b0;
          last_id        <= gnt_id;
          bus.done_cnt   <= bus.done_cnt + 8'd1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_arbiter.sv
module tb_conv_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  conv_arbiter_if #(.W(4)) bus ();

  conv_arbiter #(.W(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  // Shared converter model.
  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  always_comb bus.conv_out = bus.conv_mode ? gray2bin(bus.conv_in)
                                           : (bus.conv_in ^ (bus.conv_in >> 1));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] b;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b0;
    bus.req0_data  = 4'h0; bus.req1_data  = 4'h0;
    bus.req0_mode  = 1'b0; bus.req1_mode  = 1'b0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;

    // ---- reset state (request pending must not be readied)
    tick(); tick();
    check("rst_req0_ready", {7'd0, bus.req0_ready}, 8'd0);
    check("rst_rsp0_valid", {7'd0, bus.rsp0_valid}, 8'd0);
    check("rst_rsp1_valid", {7'd0, bus.rsp1_valid}, 8'd0);
    check("rst_rsp_data",   {4'd0, bus.rsp_data},   8'd0);
    check("rst_conv_in",    {4'd0, bus.conv_in},    8'd0);
    check("rst_conv_mode",  {7'd0, bus.conv_mode},  8'd0);
    check("rst_busy",       {7'd0, bus.busy},       8'd0);
    check("rst_done_cnt",   bus.done_cnt,           8'd0);
    bus.req0_valid = 1'b0;
    rst = 1'b0;
    tick();

    // ---- req0 bin->Gray 0110 -> 0101
    bus.req0_valid = 1'b1; bus.req0_data = 4'b0110; bus.req0_mode = 1'b0;
    bus.rsp0_ready = 1'b1;
    #1;
    check("t1_req0_ready", {7'd0, bus.req0_ready}, 8'd1);
    tick();
    bus.req0_valid = 1'b0;
    check("t1_conv_busy",  {7'd0, bus.busy},       8'd1);
    check("t1_conv_in",    {4'd0, bus.conv_in},    8'h6);
    check("t1_conv_ready", {7'd0, bus.req0_ready}, 8'd0);
    check("t1_rsp0_early", {7'd0, bus.rsp0_valid}, 8'd0);
    tick();
    check("t1_rsp0_valid", {7'd0, bus.rsp0_valid}, 8'd1);
    check("t1_rsp1_valid", {7'd0, bus.rsp1_valid}, 8'd0);
    check("t1_rsp_data",   {4'd0, bus.rsp_data},   8'h5);
    tick();
    check("t1_done_cnt",   bus.done_cnt,           8'd1);
    check("t1_idle_busy",  {7'd0, bus.busy},       8'd0);
    check("t1_rsp0_drop",  {7'd0, bus.rsp0_valid}, 8'd0);
    check("t1_conv_keep",  {4'd0, bus.conv_in},    8'h6);

    // ---- req1 Gray->bin 1000 -> 1111
    bus.req1_valid = 1'b1; bus.req1_data = 4'b1000; bus.req1_mode = 1'b1;
    bus.rsp1_ready = 1'b1;
    #1;
    check("t2_req1_ready", {7'd0, bus.req1_ready}, 8'd1);
    check("t2_req0_ready", {7'd0, bus.req0_ready}, 8'd0);
    tick();
    bus.req1_valid = 1'b0;
    check("t2_conv_mode",  {7'd0, bus.conv_mode},  8'd1);
    check("t2_conv_in",    {4'd0, bus.conv_in},    8'h8);
    tick();
    check("t2_rsp1_valid", {7'd0, bus.rsp1_valid}, 8'd1);
    check("t2_rsp0_valid", {7'd0, bus.rsp0_valid}, 8'd0);
    check("t2_rsp_data",   {4'd0, bus.rsp_data},   8'hF);
    tick();
    check("t2_done_cnt",   bus.done_cnt,           8'd2);

    // ---- response back-pressure: rsp0_ready low 5 cycles
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_data = 4'b0011; bus.req0_mode = 1'b0;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    bus.req1_valid = 1'b1;   // must wait
    bus.rsp1_ready = 1'b1;   // wrong channel, must be ignored
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp0_valid", {7'd0, bus.rsp0_valid}, 8'd1);
      check("bp_rsp_data",   {4'd0, bus.rsp_data},   8'h2);
      check("bp_req_ready",  {6'd0, bus.req1_ready, bus.req0_ready}, 8'd0);
      check("bp_busy",       {7'd0, bus.busy},       8'd1);
      tick();
    end
    bus.rsp0_ready = 1'b1;
    tick();
    check("bp_done_cnt",   bus.done_cnt,           8'd3);
    check("bp_req1_wait",  {7'd0, bus.req1_ready}, 8'd1);
    bus.req1_valid = 1'b0;

    // ---- round-robin with both valid from reset: 0,1,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_data = 4'h1; bus.req0_mode = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_data = 4'h2; bus.req1_mode = 1'b0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("rr_req0_ready", {7'd0, bus.req0_ready}, (k % 2 == 0) ? 8'd1 : 8'd0);
      check("rr_req1_ready", {7'd0, bus.req1_ready}, (k % 2 == 1) ? 8'd1 : 8'd0);
      tick(); tick();
      check("rr_rsp0_valid", {7'd0, bus.rsp0_valid}, (k % 2 == 0) ? 8'd1 : 8'd0);
      check("rr_rsp1_valid", {7'd0, bus.rsp1_valid}, (k % 2 == 1) ? 8'd1 : 8'd0);
      check("rr_rsp_data",   {4'd0, bus.rsp_data},   (k % 2 == 0) ? 8'h1 : 8'h3);
      tick();
    end
    check("rr_done_cnt", bus.done_cnt, 8'd4);
    bus.req1_valid = 1'b0;

    // ---- reset during CONV discards the transaction
    bus.req0_data = 4'h5;
    tick();
    check("rc_in_conv", {7'd0, bus.busy}, 8'd1);
    bus.req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rc_busy",     {7'd0, bus.busy},     8'd0);
    check("rc_conv_in",  {4'd0, bus.conv_in},  8'd0);
    check("rc_done_cnt", bus.done_cnt,         8'd0);
    check("rc_rsp",      {6'd0, bus.rsp1_valid, bus.rsp0_valid}, 8'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rc_no_rsp", {6'd0, bus.rsp1_valid, bus.rsp0_valid}, 8'd0);
    end
    check("rc_done_after", bus.done_cnt, 8'd0);

    // ---- sweep 0..15 bin->Gray on req0
    for (int i = 0; i < 16; i++) begin
      b = 4'(i);
      bus.req0_valid = 1'b1; bus.req0_data = b; bus.req0_mode = 1'b0;
      tick();
      bus.req0_valid = 1'b0;
      tick();
      check("sw_rsp0_valid", {7'd0, bus.rsp0_valid}, 8'd1);
      check("sw_rsp_data",   {4'd0, bus.rsp_data},   {4'd0, b ^ (b >> 1)});
      tick();
    end
    check("sw_done_cnt", bus.done_cnt, 8'd16);

    // ---- 240 more transactions: done_cnt wraps 255 -> 0
    for (int i = 0; i < 239; i++) begin
      bus.req0_valid = 1'b1;
      tick();
      bus.req0_valid = 1'b0;
      tick(); tick();
    end
    check("wrap_255", bus.done_cnt, 8'd255);
    bus.req0_valid = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    tick(); tick();
    check("wrap_0", bus.done_cnt, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_arbiter.md
CONV_ARBITER -- requirements
Module: conv_arbiter

Interface
REQ-001 Parameter W, default 4, SHALL set the code width in bits for all data ports.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be asynchronous, active-high reset.
REQ-004 req0_valid/req1_valid  input  1  SHALL flag a conversion request from requester 0/1.
REQ-005 req0_ready/req1_ready  output  1  SHALL flag request acceptance; a request transfers on valid&ready at the clock edge.
REQ-006 req0_data/req1_data  input  W  SHALL carry the code to convert.
REQ-007 req0_mode/req1_mode  input  1  SHALL select the conversion: 0 = binary->Gray, 1 = Gray->binary.
REQ-008 conv_in  output  W  SHALL drive the shared combinational converter's input.
REQ-009 conv_mode  output  1  SHALL drive the shared converter's mode select.
REQ-010 conv_out  input  W  SHALL carry the shared converter's result.
REQ-011 rsp0_valid/rsp1_valid  output  1  SHALL flag a result available for requester 0/1.
REQ-012 rsp0_ready/rsp1_ready  input  1  SHALL flag result consumption by requester 0/1.
REQ-013 rsp_data  output  W  SHALL carry the result, shared by both response channels.
REQ-014 busy  output  1  SHALL be high in any state other than IDLE.
REQ-015 done_cnt  output  8  SHALL count completed transactions.

Function
REQ-016 FSM states SHALL be IDLE, CONV and RESP.
REQ-017 In IDLE, reqN_ready SHALL be combinational: high only for the granted requester with reqN_valid high.
REQ-018 In CONV and RESP, both reqN_ready SHALL be 0.
REQ-019 Arbitration SHALL be round-robin.
REQ-020 If only one requester is valid, that requester SHALL be granted.
REQ-021 If both requesters are valid, the requester other than last_id SHALL be granted.
REQ-022 On acceptance: data SHALL be latched into conv_in, mode into conv_mode, and the winner into a grant id; FSM -> CONV.
REQ-023 In CONV, conv_in and conv_mode SHALL be stable, and conv_out SHALL be captured into rsp_data at the cycle end; FSM -> RESP.
REQ-024 In RESP, rsp{id}_valid SHALL be high and the other rspN_valid low; rsp_data SHALL hold stable until rsp{id}_ready.
REQ-025 On rsp{id}_valid&rsp{id}_ready: last_id <= id, done_cnt increments, FSM -> IDLE.
REQ-026 done_cnt SHALL wrap from 255 to 0.
REQ-027 Latency SHALL be: accepted at edge N -> rsp valid from cycle N+1 through the response handshake edge.
REQ-028 Peak throughput SHALL be one transaction per 3 cycles.
REQ-029 conv_in and conv_mode SHALL retain their last values after a transaction until the next acceptance.
REQ-030 rspN_ready asserted while the matching rspN_valid is low SHALL be ignored.
REQ-031 Requests valid during busy SHALL wait; the block imposes no requirement for reqN_valid to be held.

Reset
REQ-032 While rst is high: FSM=IDLE, req*_ready=0, rsp*_valid=0, rsp_data=0, conv_in=0, conv_mode=0, busy=0, done_cnt=0, last_id=1.
REQ-033 rst asserted mid-transaction (CONV or RESP) SHALL discard that transaction with no response and no done_cnt increment.
REQ-034 The first arbitration after reset, with both requesters valid, SHALL grant requester 0.

Verification
REQ-035 req0 data=4'b0110 mode=0, rsp0_ready=1 -> rsp0_valid with rsp_data=4'b0101 in the cycle after CONV; done_cnt=1.
REQ-036 req1 data=4'b1000 mode=1 -> rsp1_valid, rsp_data=4'b1111, conv_mode=1 during CONV.
REQ-037 Both requesters continuously valid after reset -> grants in order 0,1,0,1; each rsp on the correct channel.
REQ-038 rsp0_ready held low 5 cycles in RESP -> rsp0_valid and rsp_data stable, req*_ready=0, busy=1 throughout.
REQ-039 rst pulsed while in CONV -> all outputs 0 immediately, no rsp*_valid afterward, done_cnt=0.
REQ-040 Sweep req0 through binary 0..15 with mode=0 -> each rsp_data = b ^ (b>>1), e.g. 15 -> 4'b1000; done_cnt=16.
